// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller slice.
//   state_e       : controller FSM encoding (IDLE, WAIT, READY)
//   RW_* / SIZE_* : encodings of the RW and DATASIZE request inputs
//   req_t         : one latched access request
//   byte_en()     : 2-bit byte-write enable for a given size / address LSB
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int DEFAULT_LATENCY = 4;

    typedef struct packed {
        logic        rw;
        logic        size;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    // Word: both lanes. Byte: even address -> low lane, odd -> high lane.
    function automatic logic [1:0] byte_en(input logic size, input logic a0);
        if (size == SIZE_WORD) return 2'b11;
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_ctrl_mem_array.sv
// mem_array: synchronous word-wide RAM with byte-write enable and a
// registered read port.
//   clk   : clock
//   rst   : async active-high reset, clears only the read register
//   en    : perform an access this edge
//   we    : byte-write enables (00 = read)
//   addr  : word address
//   wdata : write word (lanes selected by we)
//   rdata : registered read word; changes only on a read access
module mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] rdata_q, rdata_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem[addr][7:0]  <= wdata[7:0];
            if (we[1]) mem[addr][15:8] <= wdata[15:8];
        end
    end

    // Writes leave the read register untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (en && we == 2'b00) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= 16'h0000;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: control-store memory interface. A request held on MEMEN is
// latched in IDLE, waits LATENCY-1 further edges in WAIT, and completes on
// the edge entering READY, where R is high for exactly one cycle.
//   clk, reset : clock, async active-high reset
//   MEMEN      : access request, held until R
//   RW         : 1 = write, 0 = read
//   DATASIZE   : 1 = word, 0 = byte
//   addr       : byte address (MAR)
//   wdata      : write data (MDR)
//   rdata      : registered read word
//   R          : ready pulse
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LATENCY        = DEFAULT_LATENCY,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEMEN,
    input  logic        RW,
    input  logic        DATASIZE,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        R
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        r_q, r_d;
    logic        mem_go;
    req_t        cur;
    logic        unused_req;

    // With LATENCY=1 the access fires on the start edge itself, before the
    // latch holds anything, so the live inputs are used while in IDLE.
    always_comb begin
        cur = (state_q == IDLE) ? '{rw: RW, size: DATASIZE, addr: addr, wdata: wdata}
                                : req_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        mem_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEMEN) begin
                    req_d = cur;
                    if (LATENCY == 1) begin
                        state_d = READY;
                        mem_go  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!MEMEN) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = READY;
                        mem_go  = 1'b1;
                    end
                end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        r_d = (state_d == READY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            r_q     <= r_d;
        end
    end

    // Address bits above the array size are dropped, so addresses wrap.
    assign unused_req = ^cur;

    // Gating with reset keeps an edge seen during reset from touching the RAM.
    mem_array #(.AW(MEM_WORDS_LOG2)) u_mem (
        .clk   (clk),
        .rst   (reset),
        .en    (mem_go & ~reset),
        .we    ((cur.rw == RW_WRITE) ? byte_en(cur.size, cur.addr[0]) : 2'b00),
        .addr  (cur.addr[MEM_WORDS_LOG2:1]),
        .wdata (cur.wdata),
        .rdata (rdata)
    );

    assign R = r_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEMEN, RW, DATASIZE;
  logic [15:0] addr, wdata, rdata;
  logic        R;
  logic        memen1, rw1, size1;
  logic [15:0] addr1, wdata1, rdata1;
  logic        r1;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mdl [0:1023];
  logic [15:0] exp_rd;
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  mem_ctrl #(.LATENCY(LAT), .MEM_WORDS_LOG2(10)) u_dut (
    .clk(clk), .reset(reset), .MEMEN(MEMEN), .RW(RW), .DATASIZE(DATASIZE),
    .addr(addr), .wdata(wdata), .rdata(rdata), .R(R)
  );

  mem_ctrl #(.LATENCY(1), .MEM_WORDS_LOG2(10)) u_dut1 (
    .clk(clk), .reset(reset), .MEMEN(memen1), .RW(rw1), .DATASIZE(size1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .R(r1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: word index is the byte address / 2 modulo 1024.
  task automatic mdl_write(input logic sz, input logic [15:0] a, input logic [15:0] wd);
    int w;
    w = int'((a >> 1) & 16'h03FF);
    if (sz) mdl[w] = wd;
    else if (a[0]) mdl[w][15:8] = wd[15:8];
    else mdl[w][7:0] = wd[7:0];
  endtask

  // Called at a negedge with the DUT idle. abort_at>0 drops MEMEN after that
  // many edges; scr garbles the request inputs after the start edge.
  task automatic acc(input logic rw_i, input logic sz_i, input logic [15:0] a_i,
                     input logic [15:0] wd_i, input int abort_at, input bit scr);
    bit ab;
    ab = (abort_at > 0);
    MEMEN = 1'b1; RW = rw_i; DATASIZE = sz_i; addr = a_i; wdata = wd_i;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c == LAT && !ab) begin
        chk("r_pulse", {15'd0, R}, 16'd1);
        if (rw_i) mdl_write(sz_i, a_i, wd_i);
        else begin
          exp_rd = mdl[int'((a_i >> 1) & 16'h03FF)];
          last_rd = rdata;
        end
        chk("rdata", rdata, exp_rd);
        MEMEN = 1'b0;
      end else begin
        chk("r_low", {15'd0, R}, 16'd0);
        chk("rdata_hold", rdata, exp_rd);
      end
      if (ab && c == abort_at) MEMEN = 1'b0;
      if (scr && c == 1) begin
        addr = 16'($urandom); wdata = 16'($urandom);
        RW = 1'($urandom); DATASIZE = 1'($urandom);
      end
    end
    MEMEN = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MEMEN = 0; RW = 0; DATASIZE = 0; addr = 0; wdata = 0;
    memen1 = 0; rw1 = 0; size1 = 0; addr1 = 0; wdata1 = 0;
    exp_rd = 16'h0000; last_rd = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_r", {15'd0, R}, 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_r1", {15'd0, r1}, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_r", {15'd0, R}, 16'd0);

    // Preload words 0..15 and the directed locations.
    for (int w = 0; w < 16; w++) acc(1, 1, 16'(w * 2), 16'($urandom), 0, 0);
    acc(1, 1, 16'h0030, 16'h0A0A, 0, 0);

    // Read latency and odd-address word read.
    acc(1, 1, 16'h0020, 16'h1234, 0, 0);
    acc(0, 1, 16'h0021, 16'h0000, 0, 0);
    chk("lat_read", last_rd, 16'h1234);

    // Byte-lane writes.
    acc(1, 1, 16'h0040, 16'hFFFF, 0, 0);
    acc(1, 0, 16'h0040, 16'h00AB, 0, 0);
    acc(1, 0, 16'h0041, 16'hCD00, 0, 0);
    acc(0, 1, 16'h0040, 16'h0000, 0, 0);
    chk("byte_merge", last_rd, 16'hCDAB);
    acc(0, 0, 16'h0041, 16'h0000, 0, 0);
    chk("byte_read_full", last_rd, 16'hCDAB);

    // Abort after 2 edges, and at the last possible edge.
    acc(1, 1, 16'h0030, 16'h5555, 2, 0);
    acc(1, 1, 16'h0030, 16'h6666, LAT - 1, 0);
    acc(0, 1, 16'h0030, 16'h0000, 0, 0);
    chk("abort_nowrite", last_rd, 16'h0A0A);

    // Wrap and in-flight input changes.
    acc(1, 1, 16'h0802, 16'hBEEF, 0, 1);
    acc(0, 1, 16'h0002, 16'h0000, 0, 1);
    chk("wrap", last_rd, 16'hBEEF);

    // Reset during WAIT of a write.
    MEMEN = 1; RW = 1; DATASIZE = 1; addr = 16'h0030; wdata = 16'h7777;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rstw_r", {15'd0, R}, 16'd0);
    chk("rstw_rdata", rdata, 16'h0000);
    exp_rd = 16'h0000;
    @(negedge clk); MEMEN = 0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rstw_hold", rdata, 16'h0000);
    acc(0, 1, 16'h0030, 16'h0000, 0, 0);
    chk("rstw_nowrite", last_rd, 16'h0A0A);

    // Reset during the READY cycle of a read.
    MEMEN = 1; RW = 0; DATASIZE = 1; addr = 16'h0002;
    repeat (LAT) @(negedge clk);
    chk("rstr_pre_r", {15'd0, R}, 16'd1);
    #2 reset = 1'b1;
    #1 chk("rstr_r", {15'd0, R}, 16'd0);
    chk("rstr_rdata", rdata, 16'h0000);
    exp_rd = 16'h0000;
    MEMEN = 0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Random traffic over words 0..15 with random high (wrapped) bits.
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      int ab;
      a = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, LAT - 1) : 0;
      acc(1'($urandom), 1'($urandom), a, 16'($urandom), ab, bit'($urandom_range(0, 1)));
    end

    // Back-to-back on LATENCY=1: write, then held reads.
    memen1 = 1; rw1 = 1; size1 = 1; addr1 = 16'h0004; wdata1 = 16'h1357;
    @(negedge clk);
    chk("b2b_r_w", {15'd0, r1}, 16'd1);
    rw1 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("b2b_r", {15'd0, r1}, (c % 2 == 0) ? 16'd0 : 16'd1);
      if (c % 2 == 1) chk("b2b_rdata", rdata1, 16'h1357);
    end
    memen1 = 0;
    repeat (2) @(negedge clk);
    chk("b2b_idle", {15'd0, r1}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
